kbd_event_scheduler: RTL and testbench

- Sits between the key-code sources and the Mac Plus keyboard block's `kbd_strobe`/`kbd_data` input.
- Arbitrates two sources, the host keyboard translator and the OSD/autotype injector, into one FIFO.
- Issues FIFO entries to the keyboard block one at a time. The next key is held back until the previous one has been taken by the Mac, or until a timeout expires, so no queued key overwrites an undelivered one.

---
 rtl/kbd_event_scheduler.sv | 122 ++++++++++++
 tb/tb_kbd_event_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_event_scheduler.sv
// Queues host and injector key codes and paces them one at a time onto the
// keyboard block's toggle-strobe interface, waiting for an ack or timeout per key.
module kbd_event_scheduler #(
    parameter int unsigned           DEPTH   = 8,
    parameter int unsigned           AW      = 3,
    parameter int unsigned           CNT_W   = 20,
    parameter logic [CNT_W-1:0]      TIMEOUT = 20'hFFFFF,
    parameter logic [CNT_W-1:0]      GAP     = 20'h01000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          host_strobe,
    input  logic [7:0]    host_data,
    input  logic          inj_valid,
    input  logic [7:0]    inj_data,
    output logic          inj_ready,
    input  logic          key_taken,
    input  logic          flush,
    output logic          kbd_strobe,
    output logic [7:0]    kbd_data,
    output logic [AW:0]   fifo_level,
    output logic          overflow,
    output logic          busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT - 1'b1;
    localparam logic [CNT_W-1:0] GAP_LAST     = GAP - 1'b1;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StGap} state_e;

    state_e           state_q;
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       mem_q [DEPTH];

    logic       full;
    logic       empty;
    logic       push_host;
    logic       push_inj;
    logic       push;
    logic [7:0] push_data;

    // Full/empty come from registered pointers, so a same-cycle pop never frees a slot early.
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign inj_ready  = !full && !host_strobe && !flush;
    assign push_host  = en && host_strobe && !full && !flush;
    assign push_inj   = en && inj_valid && inj_ready;
    assign push       = push_host || push_inj;
    assign push_data  = host_strobe ? host_data : inj_data;
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign busy       = (state_q != StIdle) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            kbd_strobe <= 1'b0;
            kbd_data   <= 8'h00;
            overflow   <= 1'b0;
        end else if (en) begin
            if (flush) begin
                // Output strobe/data are left alone so a flush never looks like a new key.
                state_q  <= StIdle;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (host_strobe && full) begin
                    overflow <= 1'b1;
                end
                case (state_q)
                    StIdle: begin
                        if (!empty) begin
                            state_q <= StIssue;
                        end
                    end
                    StIssue: begin
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        kbd_data   <= mem_q[rd_ptr_q[AW-1:0]];
                        kbd_strobe <= ~kbd_strobe;
                        cnt_q      <= '0;
                        state_q    <= StWaitAck;
                    end
                    StWaitAck: begin
                        if (key_taken || (cnt_q == TIMEOUT_LAST)) begin
                            cnt_q   <= '0;
                            state_q <= StGap;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StGap: begin
                        if (cnt_q == GAP_LAST) begin
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kbd_event_scheduler.sv
// Directed bench for kbd_event_scheduler with shortened TIMEOUT/GAP so pacing
// and timeout windows can be measured exactly in cycles.
module tb_kbd_event_scheduler;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned AW      = 3;
    localparam int unsigned CNT_W   = 20;
    localparam int          TO_I    = 40;
    localparam int          GAP_I   = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic          host_strobe;
    logic [7:0]    host_data;
    logic          inj_valid;
    logic [7:0]    inj_data;
    logic          inj_ready;
    logic          key_taken;
    logic          flush;
    logic          kbd_strobe;
    logic [7:0]    kbd_data;
    logic [AW:0]   fifo_level;
    logic          overflow;
    logic          busy;

    kbd_event_scheduler #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .CNT_W   (CNT_W),
        .TIMEOUT (20'd40),
        .GAP     (20'd6)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .host_strobe (host_strobe),
        .host_data   (host_data),
        .inj_valid   (inj_valid),
        .inj_data    (inj_data),
        .inj_ready   (inj_ready),
        .key_taken   (key_taken),
        .flush       (flush),
        .kbd_strobe  (kbd_strobe),
        .kbd_data    (kbd_data),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         tog_total = 0;
    logic       last_strobe = 1'b0;
    int         tog_cyc[$];
    logic [7:0] tog_data[$];
    logic [7:0] exp_data[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges, logging every strobe toggle with its cycle and data.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (kbd_strobe !== last_strobe) begin
                tog_cyc.push_back(cyc);
                tog_data.push_back(kbd_data);
                last_strobe = kbd_strobe;
                tog_total++;
            end
        end
    endtask

    task automatic clear_log();
        tog_cyc.delete();
        tog_data.delete();
        exp_data.delete();
    endtask

    task automatic wait_tog(input int n);
        int budget = 300;
        while (tog_cyc.size() < n && budget > 0) begin
            tick(1);
            budget--;
        end
        check("toggle_wait", tog_cyc.size(), n);
    endtask

    task automatic wait_idle();
        int budget = 300;
        while (busy && budget > 0) begin
            tick(1);
            budget--;
        end
        check("idle_wait", busy, 0);
    endtask

    task automatic host_push(input logic [7:0] d);
        host_data   = d;
        host_strobe = 1'b1;
        tick(1);
        host_strobe = 1'b0;
    endtask

    task automatic inj_push(input logic [7:0] d);
        inj_data  = d;
        inj_valid = 1'b1;
        tick(1);
        inj_valid = 1'b0;
    endtask

    task automatic ack();
        key_taken = 1'b1;
        tick(1);
        key_taken = 1'b0;
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, tog_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < tog_data.size(); i++) begin
            check({tag, "_data"}, tog_data[i], exp_data[i]);
        end
    endtask

    initial begin
        logic [7:0] v;
        reset_n     = 1'b0;
        en          = 1'b1;
        host_strobe = 1'b0;
        host_data   = 8'h00;
        inj_valid   = 1'b0;
        inj_data    = 8'h00;
        key_taken   = 1'b0;
        flush       = 1'b0;
        #22;
        reset_n = 1'b1;
        tick(1);
        check("rst_strobe", kbd_strobe, 0);
        check("rst_data", kbd_data, 8'h00);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_inj_ready", inj_ready, 1);

        // Single key: toggle two edges after the push, busy until GAP expires.
        clear_log();
        host_data   = 8'h33;
        host_strobe = 1'b1;
        tick(1);
        host_strobe = 1'b0;
        check("single_level_n", fifo_level, 1);
        check("single_strobe_n", kbd_strobe, 0);
        tick(1);
        check("single_strobe_n1", kbd_strobe, 0);
        tick(1);
        check("single_strobe_n2", kbd_strobe, 1);
        check("single_data", kbd_data, 8'h33);
        check("single_level_n2", fifo_level, 0);
        check("single_busy", busy, 1);
        ack();
        tick(GAP_I - 1);
        check("single_busy_gap", busy, 1);
        tick(1);
        check("single_idle", busy, 0);

        // Pacing with key_taken 10 cycles after each toggle.
        clear_log();
        exp_data = '{8'h01, 8'h02, 8'h03};
        host_push(8'h01);
        host_push(8'h02);
        host_push(8'h03);
        for (int i = 0; i < 3; i++) begin
            wait_tog(i + 1);
            tick(9);
            ack();
        end
        wait_idle();
        tick(20);
        check_log("pace");
        if (tog_cyc.size() == 3) begin
            check("pace_space01", tog_cyc[1] - tog_cyc[0], 10 + 1 + GAP_I + 1);
            check("pace_space12", tog_cyc[2] - tog_cyc[1], 10 + 1 + GAP_I + 1);
        end

        // Timeout: no ack for the first key.
        clear_log();
        exp_data = '{8'h55, 8'h66};
        host_push(8'h55);
        host_push(8'h66);
        wait_tog(1);
        wait_tog(2);
        if (tog_cyc.size() == 2) begin
            check("timeout_space", tog_cyc[1] - tog_cyc[0], TO_I + GAP_I + 2);
        end
        ack();
        wait_idle();
        check_log("timeout");

        // Arbitration, fill to full, overflow.
        clear_log();
        host_data   = 8'hA1;
        host_strobe = 1'b1;
        inj_data    = 8'hB2;
        inj_valid   = 1'b1;
        #1;
        check("arb_inj_ready_blocked", inj_ready, 0);
        tick(1);
        host_strobe = 1'b0;
        exp_data.push_back(8'hA1);
        for (int k = 0; k < 8; k++) begin
            v = 8'hB2 + 8'(k);
            inj_data = v;
            #1;
            check("fill_inj_ready", inj_ready, 1);
            exp_data.push_back(v);
            tick(1);
        end
        check("full_level", fifo_level, 8);
        check("full_inj_ready", inj_ready, 0);
        inj_valid = 1'b0;
        check("full_no_overflow_yet", overflow, 0);
        host_push(8'hC3);
        check("overflow_set", overflow, 1);
        check("overflow_level", fifo_level, 8);
        for (int i = 0; i < 9; i++) begin
            wait_tog(i + 1);
            ack();
        end
        wait_idle();
        check_log("arb");
        check("arb_level_drained", fifo_level, 0);
        check("overflow_sticky", overflow, 1);

        // Wrap: 20 keys, alternating sources, in batches of 5.
        for (int b = 0; b < 4; b++) begin
            clear_log();
            for (int j = 0; j < 5; j++) begin
                v = 8'h10 + 8'(b * 5 + j);
                exp_data.push_back(v);
                if (j % 2 == 0) host_push(v);
                else inj_push(v);
            end
            for (int j = 0; j < 5; j++) begin
                wait_tog(j + 1);
                ack();
            end
            wait_idle();
            check_log("wrap");
        end
        check("wrap_level", fifo_level, 0);

        // Flush during WAIT_ACK with 4 entries queued.
        clear_log();
        for (int j = 0; j < 5; j++) begin
            host_push(8'h71 + 8'(j));
        end
        check("flush_pre_level", fifo_level, 4);
        check("flush_pre_toggles", tog_cyc.size(), 1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush_level", fifo_level, 0);
        check("flush_overflow", overflow, 0);
        check("flush_busy", busy, 0);
        check("flush_strobe", kbd_strobe, tog_total % 2);
        check("flush_data", kbd_data, 8'h71);
        tick(60);
        check("flush_no_toggle", tog_cyc.size(), 1);

        // en=0 blocks capture.
        en = 1'b0;
        host_push(8'h99);
        tick(3);
        check("en0_level", fifo_level, 0);
        en = 1'b1;
        tick(2);
        check("en0_busy", busy, 0);

        // Reset asserted mid-GAP.
        clear_log();
        host_push(8'h44);
        wait_tog(1);
        ack();
        tick(2);
        check("gap_busy", busy, 1);
        check("gap_strobe", kbd_strobe, tog_total % 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_strobe", kbd_strobe, 0);
        check("async_rst_data", kbd_data, 8'h00);
        check("async_rst_level", fifo_level, 0);
        check("async_rst_overflow", overflow, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        reset_n     = 1'b1;
        last_strobe = 1'b0;
        tog_total   = 0;
        clear_log();
        tick(60);
        check("post_rst_no_toggle", tog_cyc.size(), 0);
        check("post_rst_strobe", kbd_strobe, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
